ac97_frame_tx: RTL and testbench



---
 rtl/ac97_pkg.sv | 31 +++
 rtl/ac97_slot_packer.sv | 40 ++++
 rtl/ac97_frame_tx.sv | 108 ++++++++++
 tb/tb_ac97_frame_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// Shared constants, tag layout and command FSM encoding for the AC'97 link transmitter.
`timescale 1ns/1ps
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SYNC_BITS  = 16;
  localparam int SLOT_BITS  = 20;

  localparam int TAG_MSB = 255;
  localparam int S1_MSB  = 239;
  localparam int S2_MSB  = 219;
  localparam int S3_MSB  = 199;
  localparam int S4_MSB  = 179;

  localparam int TAG_FRAME_VALID = 15;
  localparam int TAG_S1_VALID    = 14;
  localparam int TAG_S2_VALID    = 13;
  localparam int TAG_S3_VALID    = 12;
  localparam int TAG_S4_VALID    = 11;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

  // Unsigned-offset 18-bit sample to left-justified two's-complement slot.
  function automatic logic [SLOT_BITS-1:0] pcm_to_slot(input logic [17:0] s);
    return {~s[17], s[16:0], 2'b00};
  endfunction

endpackage

// File: rtl/ac97_slot_packer.sv
// Combinational assembly of one 256-bit AC'97 output frame from tag valids and payloads.
`timescale 1ns/1ps
module ac97_slot_packer
  import ac97_pkg::*;
(
  input  logic                  cmd_valid_i,
  input  logic                  pcm_valid_i,
  input  logic [6:0]            cmd_addr_i,
  input  logic [15:0]           cmd_data_i,
  input  logic [17:0]           pcm_left_i,
  input  logic [17:0]           pcm_right_i,
  output logic [FRAME_BITS-1:0] frame_o
);

  logic [15:0] tag;

  always_comb begin
    tag                  = '0;
    tag[TAG_S1_VALID]    = cmd_valid_i;
    tag[TAG_S2_VALID]    = cmd_valid_i;
    tag[TAG_S3_VALID]    = pcm_valid_i;
    tag[TAG_S4_VALID]    = pcm_valid_i;
    tag[TAG_FRAME_VALID] = cmd_valid_i | pcm_valid_i;
  end

  always_comb begin
    frame_o              = '0;
    frame_o[TAG_MSB -: 16] = tag;
    // Slots without a tag bit stay zero so idle frames are entirely quiet.
    if (cmd_valid_i) begin
      frame_o[S1_MSB -: SLOT_BITS] = {1'b0, cmd_addr_i, 12'h000};
      frame_o[S2_MSB -: SLOT_BITS] = {cmd_data_i, 4'h0};
    end
    if (pcm_valid_i) begin
      frame_o[S3_MSB -: SLOT_BITS] = pcm_to_slot(pcm_left_i);
      frame_o[S4_MSB -: SLOT_BITS] = pcm_to_slot(pcm_right_i);
    end
  end

endmodule

// File: rtl/ac97_frame_tx.sv
// AC'97 link transmitter: bit counter, command FSM, frame shift register and registered link outputs.
`timescale 1ns/1ps
module ac97_frame_tx
  import ac97_pkg::*;
(
  input  logic        BIT_CLK,
  input  logic        RESET,
  input  logic [17:0] PCM_LEFT,
  input  logic [17:0] PCM_RIGHT,
  input  logic        PCM_EN,
  input  logic        CMD_VALID,
  input  logic [6:0]  CMD_ADDR,
  input  logic [15:0] CMD_DATA,
  output logic        CMD_READY,
  output logic        SYNC,
  output logic        SDATA_OUT,
  output logic        FRAME_SIG
);

  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic                  hold_q;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame;
  logic                  sync_q, sync_d;
  logic                  sdata_q, sdata_d;
  logic                  fsig_q, fsig_d;
  cmd_state_e            state_q, state_d;
  logic [6:0]            cmd_addr_q, cmd_addr_d;
  logic [15:0]           cmd_data_q, cmd_data_d;
  logic                  load;

  // hold_q keeps bit_cnt at 255 for one cycle after reset so FRAME_SIG fires before the first frame.
  assign load = (bit_cnt_q == 8'd255) && !hold_q;

  ac97_slot_packer u_packer (
    .cmd_valid_i (state_q == CMD_PEND),
    .pcm_valid_i (PCM_EN),
    .cmd_addr_i  (cmd_addr_q),
    .cmd_data_i  (cmd_data_q),
    .pcm_left_i  (PCM_LEFT),
    .pcm_right_i (PCM_RIGHT),
    .frame_o     (frame)
  );

  always_comb begin
    bit_cnt_d = hold_q ? bit_cnt_q : bit_cnt_q + 8'd1;
    if (load) begin
      sdata_d = frame[FRAME_BITS-1];
      shift_d = {frame[FRAME_BITS-2:0], 1'b0};
    end else begin
      sdata_d = shift_q[FRAME_BITS-1];
      shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
    end
    sync_d = (bit_cnt_d < 8'(SYNC_BITS));
    fsig_d = (bit_cnt_d == 8'd255);
  end

  // Handshake: a command transfers on an edge where CMD_VALID and CMD_READY are both high;
  // CMD_READY stays low until the pending command has been loaded into a frame.
  always_comb begin
    state_d    = state_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    case (state_q)
      CMD_IDLE: begin
        if (CMD_VALID) begin
          state_d    = CMD_PEND;
          cmd_addr_d = CMD_ADDR;
          cmd_data_d = CMD_DATA;
        end
      end
      CMD_PEND: begin
        if (load) state_d = CMD_IDLE;
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge BIT_CLK) begin
    if (RESET) begin
      bit_cnt_q  <= 8'd255;
      hold_q     <= 1'b1;
      shift_q    <= '0;
      sync_q     <= 1'b0;
      sdata_q    <= 1'b0;
      fsig_q     <= 1'b0;
      state_q    <= CMD_IDLE;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= 1'b0;
      shift_q    <= shift_d;
      sync_q     <= sync_d;
      sdata_q    <= sdata_d;
      fsig_q     <= fsig_d;
      state_q    <= state_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign CMD_READY = (state_q == CMD_IDLE);
  assign SYNC      = sync_q;
  assign SDATA_OUT = sdata_q;
  assign FRAME_SIG = fsig_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Bench for ac97_frame_tx: frame-level reference model plus directed and randomized frames.
`timescale 1ns/1ps
module tb_ac97_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] pcm_l, pcm_r;
  logic        pcm_en;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready, sync, sdata, fsig;

  always #5 clk = ~clk;

  ac97_frame_tx dut (
    .BIT_CLK   (clk),
    .RESET     (rst),
    .PCM_LEFT  (pcm_l),
    .PCM_RIGHT (pcm_r),
    .PCM_EN    (pcm_en),
    .CMD_VALID (cmd_valid),
    .CMD_ADDR  (cmd_addr),
    .CMD_DATA  (cmd_data),
    .CMD_READY (cmd_ready),
    .SYNC      (sync),
    .SDATA_OUT (sdata),
    .FRAME_SIG (fsig)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position in frame, pending command, current expected frame.
  int           m_cnt = 255;
  bit           m_rst_state = 1'b1;
  bit           m_hold = 1'b1;
  bit           m_pend = 1'b0;
  logic [6:0]   m_addr = '0;
  logic [15:0]  m_data = '0;
  logic [255:0] m_frame = '0;
  logic [255:0] cap = '0;
  logic [255:0] last_frame = '0;
  logic [255:0] exp_q[$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b (model cnt %0d)", tag, obs, exp, m_cnt);
    end
  endtask

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_slot(input logic [17:0] s);
    int         v;
    logic [17:0] t;
    v = int'(s) - 131072;
    t = 18'(v);
    return {t, 2'b00};
  endfunction

  function automatic logic [255:0] build_frame(input bit cmd, input bit pcm,
                                               input logic [6:0] a, input logic [15:0] d,
                                               input logic [17:0] l, input logic [17:0] r);
    logic [255:0] f;
    logic [15:0]  tag;
    f   = '0;
    tag = (cmd ? 16'h6000 : 16'h0000) | (pcm ? 16'h1800 : 16'h0000);
    if (tag != 16'h0000) tag = tag | 16'h8000;
    f[255:240] = tag;
    if (cmd) begin
      f[239:220] = {1'b0, a, 12'h000};
      f[219:200] = {d, 4'h0};
    end
    if (pcm) begin
      f[199:180] = to_slot(l);
      f[179:160] = to_slot(r);
    end
    return f;
  endfunction

  function automatic logic [19:0] slot_of(input logic [255:0] f, input int msb);
    return f[msb -: 20];
  endfunction

  task automatic model_edge();
    bit pend_before;
    bit load;
    pend_before = m_pend;
    load        = 1'b0;
    if (rst) begin
      m_cnt = 255; m_rst_state = 1'b1; m_hold = 1'b1; m_pend = 1'b0;
      m_frame = '0; cap = '0; exp_q.delete();
      return;
    end
    m_rst_state = 1'b0;
    if (m_hold) m_hold = 1'b0;
    else if (m_cnt == 255) begin
      load    = 1'b1;
      m_cnt   = 0;
      m_frame = build_frame(pend_before, pcm_en, m_addr, m_data, pcm_l, pcm_r);
      exp_q.push_back(m_frame);
    end else m_cnt++;
    if (load && pend_before) m_pend = 1'b0;
    if (cmd_valid && !pend_before) begin
      m_pend = 1'b1; m_addr = cmd_addr; m_data = cmd_data;
    end
  endtask

  task automatic check_outputs();
    check_bit("sync", sync, !m_rst_state && (m_cnt < 16));
    check_bit("sdata", sdata, m_frame[255 - m_cnt]);
    check_bit("frame_sig", fsig, !m_rst_state && (m_cnt == 255));
    check_bit("cmd_ready", cmd_ready, !m_pend);
    if (!m_rst_state) begin
      cap[255 - m_cnt] = sdata;
      if (m_cnt == 255 && exp_q.size() > 0) begin
        last_frame = cap;
        check_vec("frame", cap, exp_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to_cnt(input int n);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (m_cnt != n && k < 600);
    if (m_cnt != n) begin
      n_checks++;
      n_errors++;
      $error("FAIL run_to_cnt observed=%0d expected=%0d", m_cnt, n);
    end
  endtask

  initial begin
    rst = 1'b1; pcm_l = '0; pcm_r = '0; pcm_en = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (3) step();
    check_bit("reset_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    step();
    check_bit("post_reset_fsig", fsig, 1'b1);

    // Idle frames.
    run_to_cnt(255);
    run_to_cnt(255);
    check_vec("idle_frame", last_frame, 256'd0);

    // PCM extremes.
    pcm_en = 1'b1; pcm_l = 18'd131071; pcm_r = 18'd262143;
    run_to_cnt(255);
    check_vec("pcm1_tag", 256'(last_frame[255:240]), 256'(16'h9800));
    check_vec("pcm1_s3", 256'(slot_of(last_frame, 199)), 256'(20'hFFFFC));
    check_vec("pcm1_s4", 256'(slot_of(last_frame, 179)), 256'(20'h7FFFC));
    pcm_l = 18'd0; pcm_r = 18'd131072;
    run_to_cnt(255);
    check_vec("pcm2_s3", 256'(slot_of(last_frame, 199)), 256'(20'h80000));
    check_vec("pcm2_s4", 256'(slot_of(last_frame, 179)), 256'(20'h00000));

    // Command mid-frame.
    run_to_cnt(100);
    cmd_valid = 1'b1; cmd_addr = 7'h02; cmd_data = 16'h0808;
    step();
    cmd_valid = 1'b0;
    check_bit("cmd_ready_pending", cmd_ready, 1'b0);
    run_to_cnt(0);
    check_bit("cmd_ready_after_load", cmd_ready, 1'b1);
    run_to_cnt(255);
    check_vec("cmd_tag", 256'(last_frame[255:240]), 256'(16'hF800));
    check_vec("cmd_s1", 256'(slot_of(last_frame, 239)), 256'(20'h02000));
    check_vec("cmd_s2", 256'(slot_of(last_frame, 219)), 256'(20'h08080));
    run_to_cnt(255);
    check_vec("after_cmd_tag", 256'(last_frame[255:240]), 256'(16'h9800));

    // Accept on the load edge, second request held while pending.
    pcm_en = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 7'h2C; cmd_data = 16'h1234;
    step();
    cmd_addr = 7'h18; cmd_data = 16'hBEEF;
    run_to_cnt(255);
    check_vec("edge_accept_tag", 256'(last_frame[255:240]), 256'(16'h0000));
    check_bit("second_held", cmd_ready, 1'b0);
    run_to_cnt(0);
    check_bit("ready_rises", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check_bit("second_accepted", cmd_ready, 1'b0);
    run_to_cnt(255);
    check_vec("first_cmd_tag", 256'(last_frame[255:240]), 256'(16'hE000));
    check_vec("first_cmd_s1", 256'(slot_of(last_frame, 239)), 256'(20'h2C000));
    check_vec("first_cmd_s2", 256'(slot_of(last_frame, 219)), 256'(20'h12340));
    run_to_cnt(255);
    check_vec("second_cmd_s1", 256'(slot_of(last_frame, 239)), 256'(20'h18000));
    check_vec("second_cmd_s2", 256'(slot_of(last_frame, 219)), 256'(20'hBEEF0));

    // Randomized frames checked bit by bit against the model.
    repeat (6) begin
      pcm_en = 1'($urandom_range(0, 1));
      pcm_l  = 18'($urandom_range(0, 262143));
      pcm_r  = 18'($urandom_range(0, 262143));
      run_to_cnt($urandom_range(1, 250));
      if (!m_pend && $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1;
        cmd_addr  = 7'($urandom_range(0, 127));
        cmd_data  = 16'($urandom_range(0, 65535));
        step();
        cmd_valid = 1'b0;
      end
      run_to_cnt(255);
    end

    // Reset mid-frame with a command pending.
    pcm_en = 1'b1; pcm_l = 18'h2A5A5; pcm_r = 18'h15A5A;
    run_to_cnt(90);
    cmd_valid = 1'b1; cmd_addr = 7'h26; cmd_data = 16'h0F0F;
    step();
    cmd_valid = 1'b0;
    run_to_cnt(100);
    rst = 1'b1;
    step();
    check_bit("rst_sync", sync, 1'b0);
    check_bit("rst_sdata", sdata, 1'b0);
    check_bit("rst_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    step();
    check_bit("release_fsig", fsig, 1'b1);
    run_to_cnt(255);
    check_vec("post_reset_tag", 256'(last_frame[255:240]), 256'(16'h9800));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
